// File: rtl/obstacle_scheduler.sv
// obstacle_scheduler: owns the obstacle table feeding the track renderer.
// Once per frame (on the vsync assertion edge) it scrolls every active
// obstacle left by speed_in, retires those that would pass x=0, and then
// spawns at most one new obstacle into the lowest free slot.
// Word format: [14:13] type, [12:3] x position, [2:1] lane, [0] active.
// Optional build macro OBSTACLE_SCHEDULER_LANE_GUARD_EN: suppress a spawn
// while an active obstacle in the chosen lane is still close to SPAWN_X.
module obstacle_scheduler #(
    parameter int unsigned NUM_SLOTS        = 10,
    parameter logic [9:0]  SPAWN_X          = 10'd1000,
    parameter logic [5:0]  SPAWN_GAP_MIN    = 6'd24,
    parameter logic [15:0] LFSR_SEED        = 16'hACE1,
    parameter logic        VSYNC_ACTIVE_LOW = 1'b1,
    parameter logic [9:0]  MIN_GAP          = 10'd240
) (
    input  logic        system_clock_in,
    input  logic        system_reset_n_in,
    input  logic        vsync,
    input  logic        game_running_in,
    input  logic        clear_in,
    input  logic [3:0]  speed_in,
    output logic [14:0] obstacles [NUM_SLOTS],
    output logic        busy_out,
    output logic [15:0] spawn_count_out
);

    typedef enum logic [1:0] {IDLE, SCROLL, SPAWN} state_t;

    localparam logic       VS_ASSERT = ~VSYNC_ACTIVE_LOW;
    localparam logic [3:0] LAST_IDX  = 4'(NUM_SLOTS - 1);

    state_t      state, state_next;
    logic [3:0]  idx;
    logic [15:0] lfsr;
    logic [15:0] lfsr_next;
    logic [5:0]  gap_cnt;
    logic        vsync_q;
    logic        tick;
    logic        free_found;
    logic [3:0]  free_idx;
    logic [1:0]  spawn_lane;
    logic        lane_blocked;

    assign tick       = (vsync == VS_ASSERT) && (vsync_q != VS_ASSERT);
    assign lfsr_next  = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    assign spawn_lane = (lfsr[1:0] == 2'b11) ? 2'd1 : lfsr[1:0];

    // Register raw vsync for assertion-edge detection.
    always_ff @(posedge system_clock_in) begin
        if (!system_reset_n_in) vsync_q <= ~VS_ASSERT;
        else                    vsync_q <= vsync;
    end

    // FSM state register.
    always_ff @(posedge system_clock_in) begin
        if (!system_reset_n_in) state <= IDLE;
        else                    state <= state_next;
    end

    // Next-state and busy decode; clear forces the FSM back to IDLE.
    always_comb begin
        state_next = state;
        busy_out   = (state != IDLE);
        if (clear_in) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (tick && game_running_in) state_next = SCROLL;
                SCROLL:  if (idx == LAST_IDX) state_next = SPAWN;
                SPAWN:   state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // Find the lowest-index inactive slot for spawning.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            if (!free_found && !obstacles[i][0]) begin
                free_found = 1'b1;
                free_idx   = 4'(i);
            end
        end
    end

`ifdef OBSTACLE_SCHEDULER_LANE_GUARD_EN
    // Block the spawn while an active obstacle in the target lane is too close to SPAWN_X.
    always_comb begin
        lane_blocked = 1'b0;
        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            if (obstacles[i][0] && (obstacles[i][2:1] == spawn_lane) &&
                (obstacles[i][12:3] > (SPAWN_X - MIN_GAP)))
                lane_blocked = 1'b1;
        end
    end
`else
    assign lane_blocked = 1'b0;
`endif

    // Table, LFSR, spawn gap and spawn counter updates.
    always_ff @(posedge system_clock_in) begin
        if (!system_reset_n_in) begin
            for (int unsigned i = 0; i < NUM_SLOTS; i++) obstacles[i] <= '0;
            spawn_count_out <= '0;
            lfsr            <= LFSR_SEED;
            gap_cnt         <= SPAWN_GAP_MIN;
            idx             <= '0;
        end else if (clear_in) begin
            // lfsr deliberately keeps running across a clear.
            for (int unsigned i = 0; i < NUM_SLOTS; i++) obstacles[i] <= '0;
            spawn_count_out <= '0;
            gap_cnt         <= SPAWN_GAP_MIN;
            idx             <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (tick && game_running_in) begin
                        idx  <= '0;
                        lfsr <= lfsr_next;
                    end
                end
                SCROLL: begin
                    idx <= idx + 4'd1;
                    if (obstacles[idx][0]) begin
                        if (obstacles[idx][12:3] >= {6'd0, speed_in})
                            obstacles[idx][12:3] <= obstacles[idx][12:3] - {6'd0, speed_in};
                        else
                            obstacles[idx][0] <= 1'b0;
                    end
                end
                SPAWN: begin
                    if (gap_cnt != 6'd0) begin
                        gap_cnt <= gap_cnt - 6'd1;
                    end else if (free_found && !lane_blocked) begin
                        obstacles[free_idx] <= {lfsr[15:14], SPAWN_X, spawn_lane, 1'b1};
                        spawn_count_out     <= spawn_count_out + 16'd1;
                        gap_cnt             <= SPAWN_GAP_MIN + {1'b0, lfsr[6:2]};
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
